// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter and sequencer for port A of a
// simple_bidir_ram instance. Two requesters share the port with a req/ack
// handshake (ack is combinational); reads return on rvalid one cycle later.
// Optional zero sweep of the whole array is enabled by defining the macro
// RAM_PORT_ARBITER_CLEAR_EN. Without it there is no CLEAR state and busy is 0.
module ram_port_arbiter #(
  parameter int width   = 8,
  parameter int widthad = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r0_req,
  input  logic               r0_we,
  input  logic [widthad-1:0] r0_addr,
  input  logic [width-1:0]   r0_wdata,
  output logic               r0_ack,
  output logic               r0_rvalid,
  output logic [width-1:0]   r0_rdata,
  input  logic               r1_req,
  input  logic               r1_we,
  input  logic [widthad-1:0] r1_addr,
  input  logic [width-1:0]   r1_wdata,
  output logic               r1_ack,
  output logic               r1_rvalid,
  output logic [width-1:0]   r1_rdata,
  input  logic               clear_req,
  output logic               busy,
  output logic [widthad-1:0] ram_address,
  output logic               ram_wren,
  output logic [width-1:0]   ram_data,
  input  logic [width-1:0]   ram_q
);

  // Requester-indexed views of the two request ports
  logic [1:0]         req;
  logic [1:0]         we;
  logic [widthad-1:0] addr [2];
  logic [width-1:0]   wdata [2];
  logic [1:0]         grant;
  logic               rvalid_reg [2];

  // 1 = r1 was granted last, so r0 wins the next contention
  logic               last_reg;
  // Address last presented to the RAM, held through idle cycles
  logic [widthad-1:0] addr_reg;

  logic               clearing;
  logic [widthad-1:0] sweep_addr;

  assign req      = {r1_req, r0_req};
  assign we       = {r1_we, r0_we};
  assign addr[0]  = r0_addr;
  assign addr[1]  = r1_addr;
  assign wdata[0] = r0_wdata;
  assign wdata[1] = r1_wdata;

`ifdef RAM_PORT_ARBITER_CLEAR_EN
  typedef enum logic {ST_RUN, ST_CLEAR} state_t;

  localparam logic [widthad-1:0] last_addr = '1;

  state_t             state_reg;
  state_t             state_next;
  logic [widthad-1:0] sweep_reg;
  logic [widthad-1:0] sweep_next;

  // State register: reset starts a fresh sweep from address 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_CLEAR;
      sweep_reg <= '0;
    end else begin
      state_reg <= state_next;
      sweep_reg <= sweep_next;
    end
  end

  // Next state: a clear request in RUN restarts the sweep; CLEAR ignores it
  always_comb begin
    state_next = state_reg;
    sweep_next = sweep_reg;
    case (state_reg)
      ST_RUN: begin
        if (clear_req) begin
          state_next = ST_CLEAR;
          sweep_next = '0;
        end
      end
      ST_CLEAR: begin
        sweep_next = sweep_reg + widthad'(1);
        if (sweep_reg == last_addr) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // State outputs: sweep active flag and its write address
  always_comb begin
    clearing   = (state_reg == ST_CLEAR);
    sweep_addr = sweep_reg;
  end
`else
  logic unused_clear;

  assign unused_clear = clear_req;
  assign clearing     = 1'b0;
  assign sweep_addr   = '0;
`endif

  assign busy = clearing;

  // Round-robin grant: a lone requester wins, contention goes to the one not served last
  always_comb begin
    grant = 2'b00;
    if (!rst && !clearing) begin
      if (req[0] && (!req[1] || last_reg)) begin
        grant[0] = 1'b1;
      end else if (req[1]) begin
        grant[1] = 1'b1;
      end
    end
  end

  assign r0_ack = grant[0];
  assign r1_ack = grant[1];

  // RAM port mux: sweep, then the granted requester, else hold the address
  always_comb begin
    ram_wren    = 1'b0;
    ram_data    = '0;
    ram_address = addr_reg;
    if (rst) begin
      ram_address = '0;
    end else if (clearing) begin
      ram_wren    = 1'b1;
      ram_address = sweep_addr;
    end else if (grant[0]) begin
      ram_wren    = we[0];
      ram_address = addr[0];
      ram_data    = we[0] ? wdata[0] : '0;
    end else if (grant[1]) begin
      ram_wren    = we[1];
      ram_address = addr[1];
      ram_data    = we[1] ? wdata[1] : '0;
    end
  end

  // Remember the presented address and the last-granted requester
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg <= '0;
      last_reg <= 1'b1;
    end else begin
      addr_reg <= ram_address;
      if (grant[0]) begin
        last_reg <= 1'b0;
      end else if (grant[1]) begin
        last_reg <= 1'b1;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rvalid
      // Read completion strobe one cycle after a granted read
      always_ff @(posedge clk) begin
        if (rst) begin
          rvalid_reg[gi] <= 1'b0;
        end else begin
          rvalid_reg[gi] <= grant[gi] && !we[gi];
        end
      end
    end
  endgenerate

  // Pending completions are dropped as soon as reset is seen
  assign r0_rvalid = rvalid_reg[0] && !rst;
  assign r1_rvalid = rvalid_reg[1] && !rst;
  assign r0_rdata  = ram_q;
  assign r1_rdata  = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random stimulus against a transaction-level
// model of the arbiter (round-robin by last-served requester, sweep countdown,
// reference memory). Build with RAM_PORT_ARBITER_CLEAR_EN to cover the sweep.
module tb_ram_port_arbiter;
  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef RAM_PORT_ARBITER_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [W-1:0]  r0_wdata = '0, r1_wdata = '0;
  logic          clear_req = 1'b0;
  logic          r0_ack, r1_ack, r0_rvalid, r1_rvalid, busy, ram_wren;
  logic [W-1:0]  r0_rdata, r1_rdata, ram_data;
  logic [AW-1:0] ram_address;
  logic [W-1:0]  ram_q;

  // Behavioural RAM port A
  logic [W-1:0]  ram_mem [DEPTH];
  logic          mem_init = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
      ram_q <= '0;
    end else begin
      if (ram_wren) ram_mem[ram_address] <= ram_data;
      ram_q <= ram_mem[ram_address];
    end
  end

  ram_port_arbiter #(.width(W), .widthad(AW)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .clear_req(clear_req), .busy(busy),
    .ram_address(ram_address), .ram_wren(ram_wren), .ram_data(ram_data),
    .ram_q(ram_q)
  );

  // Reference model state
  int            total = 0;
  int            bad = 0;
  logic [W-1:0]  ref_mem [DEPTH];
  int            last_served;
  int            sweep_left;
  bit            exp_rv [2];
  logic [W-1:0]  exp_rd [2];
  logic [AW-1:0] exp_last_addr;
  bit            g0, g1;
  bit            obs_ack0;
  int            obs_log [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model
  task automatic step();
    bit            eg0, eg1, busy_e;
    logic [AW-1:0] sa;
    @(negedge clk);
    busy_e = (sweep_left > 0);
    sa     = AW'(DEPTH - sweep_left);
    eg0 = 1'b0;
    eg1 = 1'b0;
    if (!rst && !busy_e) begin
      if (r0_req && (!r1_req || last_served == 1)) eg0 = 1'b1;
      else if (r1_req) eg1 = 1'b1;
    end
    obs_ack0 = r0_ack;
    if (r0_ack === 1'b1) obs_log.push_back(0);
    else if (r1_ack === 1'b1) obs_log.push_back(1);
    chk("r0_ack", 32'(r0_ack), 32'(eg0));
    chk("r1_ack", 32'(r1_ack), 32'(eg1));
    chk("one_ack", 32'(r0_ack & r1_ack), 32'(0));
    chk("busy", 32'(busy), 32'(busy_e));
    chk("r0_rvalid", 32'(r0_rvalid), 32'(!rst && exp_rv[0]));
    chk("r1_rvalid", 32'(r1_rvalid), 32'(!rst && exp_rv[1]));
    if (!rst && exp_rv[0]) chk("r0_rdata", 32'(r0_rdata), 32'(exp_rd[0]));
    if (!rst && exp_rv[1]) chk("r1_rdata", 32'(r1_rdata), 32'(exp_rd[1]));
    if (rst) begin
      chk("rst_wren", 32'(ram_wren), 32'(0));
      chk("rst_addr", 32'(ram_address), 32'(0));
      chk("rst_data", 32'(ram_data), 32'(0));
    end else if (busy_e) begin
      chk("sweep_wren", 32'(ram_wren), 32'(1));
      chk("sweep_addr", 32'(ram_address), 32'(sa));
      chk("sweep_data", 32'(ram_data), 32'(0));
    end else if (eg0) begin
      chk("r0_wren", 32'(ram_wren), 32'(r0_we));
      chk("r0_addr", 32'(ram_address), 32'(r0_addr));
      if (r0_we) chk("r0_data", 32'(ram_data), 32'(r0_wdata));
    end else if (eg1) begin
      chk("r1_wren", 32'(ram_wren), 32'(r1_we));
      chk("r1_addr", 32'(ram_address), 32'(r1_addr));
      if (r1_we) chk("r1_data", 32'(ram_data), 32'(r1_wdata));
    end else begin
      chk("idle_wren", 32'(ram_wren), 32'(0));
      chk("idle_addr", 32'(ram_address), 32'(exp_last_addr));
    end
    g0 = eg0;
    g1 = eg1;
    if (rst) begin
      last_served   = 1;
      exp_rv[0]     = 1'b0;
      exp_rv[1]     = 1'b0;
      sweep_left    = CLEAR_EN ? DEPTH : 0;
      exp_last_addr = '0;
    end else begin
      exp_rv[0] = eg0 && !r0_we;
      exp_rv[1] = eg1 && !r1_we;
      if (eg0) begin
        if (r0_we) ref_mem[r0_addr] = r0_wdata;
        else exp_rd[0] = ref_mem[r0_addr];
        last_served   = 0;
        exp_last_addr = r0_addr;
        $display("txn r0 %s addr=%0h wdata=%0h", r0_we ? "wr" : "rd", r0_addr, r0_wdata);
      end
      if (eg1) begin
        if (r1_we) ref_mem[r1_addr] = r1_wdata;
        else exp_rd[1] = ref_mem[r1_addr];
        last_served   = 1;
        exp_last_addr = r1_addr;
        $display("txn r1 %s addr=%0h wdata=%0h", r1_we ? "wr" : "rd", r1_addr, r1_wdata);
      end
      if (busy_e) begin
        ref_mem[sa]   = '0;
        exp_last_addr = sa;
        sweep_left--;
      end else if (clear_req && CLEAR_EN) begin
        sweep_left = DEPTH;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Step until every raised request has been acked, dropping each req on its ack
  task automatic serve(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!r0_req && !r1_req) break;
      step();
      if (g0) r0_req = 1'b0;
      if (g1) r1_req = 1'b0;
    end
    chk("serve_timeout", 32'({r0_req, r1_req}), 32'(0));
  endtask

  task automatic wait_sweep();
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (sweep_left == 0) break;
      step();
    end
    chk("sweep_timeout", 32'(busy), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    last_served   = 1;
    sweep_left    = CLEAR_EN ? DEPTH : 0;
    exp_rv[0]     = 1'b0;
    exp_rv[1]     = 1'b0;
    exp_rd[0]     = '0;
    exp_rd[1]     = '0;
    exp_last_addr = '0;
    @(posedge clk);
    #1;
    mem_init = 1'b0;

    // Reset state
    step();
    step();
    rst = 1'b0;

`ifdef RAM_PORT_ARBITER_CLEAR_EN
    // Sweep after reset with both requesters already waiting
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 4'd9;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'd2;
    for (int i = 0; i < DEPTH; i++) step();
    chk("sweep_done", 32'(busy), 32'(0));
    serve(3);
    for (int a = 0; a < DEPTH; a++) begin
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = AW'(a);
      serve(2);
    end
    step();
`endif

    // Single requester write then read
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 4'd3; r0_wdata = 8'hA5;
    serve(2);
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 4'd3;
    serve(2);
    chk("single_rvalid", 32'(r0_rvalid), 32'(1));
    chk("single_rdata", 32'(r0_rdata), 32'(8'hA5));
    step();

    // Write/read crossover
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 4'd7; r1_wdata = 8'h3C;
    serve(2);
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 4'd7;
    serve(2);
    chk("cross_rdata", 32'(r0_rdata), 32'(8'h3C));
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'd7;
    serve(2);
    chk("r1_rdata_7", 32'(r1_rdata), 32'(8'h3C));
    step();

    // Contention: both hold req for 6 cycles, new qualifiers after each grant
    obs_log.delete();
    r0_req = 1'b1; r0_we = 1'($urandom_range(0, 1)); r0_addr = AW'($urandom_range(0, 15)); r0_wdata = W'($urandom);
    r1_req = 1'b1; r1_we = 1'($urandom_range(0, 1)); r1_addr = AW'($urandom_range(0, 15)); r1_wdata = W'($urandom);
    for (int i = 0; i < 6; i++) begin
      step();
      if (g0) begin r0_we = 1'($urandom_range(0, 1)); r0_addr = AW'($urandom_range(0, 15)); r0_wdata = W'($urandom); end
      if (g1) begin r1_we = 1'($urandom_range(0, 1)); r1_addr = AW'($urandom_range(0, 15)); r1_wdata = W'($urandom); end
    end
    r0_req = 1'b0;
    r1_req = 1'b0;
    chk("contend_count", 32'(obs_log.size()), 32'(6));
    for (int i = 0; i < obs_log.size(); i++) chk("contend_order", 32'(obs_log[i]), 32'(i % 2));
    step();

    // Random traffic with occasional clear requests
    for (int i = 0; i < 400; i++) begin
      if (!r0_req || g0) begin
        r0_req = ($urandom_range(0, 9) < 6); r0_we = 1'($urandom_range(0, 1));
        r0_addr = AW'($urandom_range(0, 15)); r0_wdata = W'($urandom);
      end
      if (!r1_req || g1) begin
        r1_req = ($urandom_range(0, 9) < 6); r1_we = 1'($urandom_range(0, 1));
        r1_addr = AW'($urandom_range(0, 15)); r1_wdata = W'($urandom);
      end
      clear_req = ($urandom_range(0, 79) == 0);
      g0 = 1'b0;
      g1 = 1'b0;
      step();
    end
    clear_req = 1'b0;
    r0_req = 1'b0;
    r1_req = 1'b0;
    wait_sweep();
    step();

`ifdef RAM_PORT_ARBITER_CLEAR_EN
    // clear_req together with an r1 read; requests during the sweep wait
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'd7;
    clear_req = 1'b1;
    step();
    chk("clear_grant", 32'(r1_req & g1), 32'(1));
    clear_req = 1'b0;
    r1_req = 1'b0;
    step();
    chk("clear_busy", 32'(busy), 32'(1));
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 4'd1;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'd7;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    wait_sweep();
    serve(3);
    step();
`endif

    // Reset in the cycle after a read ack
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 4'd3;
    serve(2);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    wait_sweep();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 4'd4;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'd5;
    step();
    chk("post_reset_r0_first", 32'(obs_ack0), 32'(1));
    if (g0) r0_req = 1'b0;
    if (g1) r1_req = 1'b0;
    serve(3);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
